// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: command handshake (key code, hold time, abort) between a
// command source and keypad_emulator.
interface keypad_emulator_if #(
    parameter int unsigned HOLD_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_key;
    logic [HOLD_W-1:0] cmd_hold;
    logic              cmd_abort;

    modport master (
        output cmd_valid,
        output cmd_key,
        output cmd_hold,
        output cmd_abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_key,
        input  cmd_hold,
        input  cmd_abort,
        output cmd_ready
    );
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 keypad matrix responder that holds a commanded key against the
// scanner's row strobes. Define KP_EMU_BOUNCE_EN to build the contact-bounce burst.
module keypad_emulator #(
    parameter int unsigned HOLD_W        = 8,
    parameter int unsigned GAP_CYCLES    = 4,
    parameter int unsigned BOUNCE_CYCLES = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       kp_row,
    output logic [3:0]       kp_col,
    keypad_emulator_if.slave cmd,
    output logic             busy,
    output logic             done
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int unsigned BNC_W = $clog2(BOUNCE_CYCLES + 1);
    localparam int unsigned W1    = (HOLD_W > GAP_W) ? HOLD_W : GAP_W;
    localparam int unsigned CNT_W = (W1 > BNC_W) ? W1 : BNC_W;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRESS  = 2'd1,
        S_GAP    = 2'd2
`ifdef KP_EMU_BOUNCE_EN
        ,
        S_BOUNCE = 2'd3
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        key_q, key_d;
    logic [3:0]        kp_col_q, kp_col_d;
    logic              pressed;
    logic              ready;
    logic [HOLD_W-1:0] hold_eff;
    logic [7:0]        key_rc;
`ifdef KP_EMU_BOUNCE_EN
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              phase_q, phase_d;
`endif

    // Returns {row strobe, column return} for a key, both one-hot-low.
    function automatic logic [7:0] key_lines(input logic [3:0] key);
        logic [7:0] rc;
        rc = '1;
        case (key)
            4'h7: rc = {4'b1110, 4'b1110};
            4'h4: rc = {4'b1110, 4'b1101};
            4'h1: rc = {4'b1110, 4'b1011};
            4'h0: rc = {4'b1110, 4'b0111};
            4'h8: rc = {4'b1101, 4'b1110};
            4'h5: rc = {4'b1101, 4'b1101};
            4'h2: rc = {4'b1101, 4'b1011};
            4'hA: rc = {4'b1101, 4'b0111};
            4'h9: rc = {4'b1011, 4'b1110};
            4'h6: rc = {4'b1011, 4'b1101};
            4'h3: rc = {4'b1011, 4'b1011};
            4'hB: rc = {4'b1011, 4'b0111};
            4'hF: rc = {4'b0111, 4'b1110};
            4'hE: rc = {4'b0111, 4'b1101};
            4'hD: rc = {4'b0111, 4'b1011};
            4'hC: rc = {4'b0111, 4'b0111};
        endcase
        return rc;
    endfunction

    assign ready         = (state_q == S_IDLE);
    assign busy          = ~ready;
    assign cmd.cmd_ready = ready;
    assign kp_col        = kp_col_q;
    assign key_rc        = key_lines(key_q);
    assign hold_eff      = (cmd.cmd_hold == '0) ? HOLD_W'(1) : cmd.cmd_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            key_q    <= '0;
            kp_col_q <= '1;
`ifdef KP_EMU_BOUNCE_EN
            hold_q   <= '0;
            phase_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            kp_col_q <= kp_col_d;
`ifdef KP_EMU_BOUNCE_EN
            hold_q   <= hold_d;
            phase_q  <= phase_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        pressed = 1'b0;
        done    = 1'b0;
`ifdef KP_EMU_BOUNCE_EN
        hold_d  = hold_q;
        phase_d = phase_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid && ready) begin
                    key_d = cmd.cmd_key;
`ifdef KP_EMU_BOUNCE_EN
                    hold_d  = hold_eff;
                    phase_d = 1'b1;
                    cnt_d   = CNT_W'(BOUNCE_CYCLES);
                    state_d = S_BOUNCE;
`else
                    cnt_d   = CNT_W'(hold_eff);
                    state_d = S_PRESS;
`endif
                end
            end
`ifdef KP_EMU_BOUNCE_EN
            S_BOUNCE: begin
                pressed = phase_q;
                phase_d = ~phase_q;
                if (cmd.cmd_abort) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = S_PRESS;
                    cnt_d   = CNT_W'(hold_q);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`endif
            S_PRESS: begin
                pressed = 1'b1;
                if (cmd.cmd_abort || cnt_q == CNT_ONE) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_ONE) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Only an exact one-hot-low match on the key's row returns a column.
        kp_col_d = (pressed && kp_row == key_rc[7:4]) ? key_rc[3:0] : 4'b1111;
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized scoreboard bench for keypad_emulator: a timeline model predicts contact,
// busy and done per clock period; a monitor compares DUT outputs every period.
`timescale 1ns/1ps
module tb_keypad_emulator;
    localparam int G  = 4;
    localparam int BC = 6;
`ifdef KP_EMU_BOUNCE_EN
    localparam int B  = BC;
`else
    localparam int B  = 0;
`endif
    localparam int NP = 16384;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] kp_row;
    logic [3:0] kp_col;
    logic       busy;
    logic       done;

    keypad_emulator_if #(.HOLD_W(8)) cmd_if ();

    keypad_emulator #(
        .HOLD_W       (8),
        .GAP_CYCLES   (G),
        .BOUNCE_CYCLES(BC)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .kp_row(kp_row),
        .kp_col(kp_col),
        .cmd   (cmd_if),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int pc = 0;
    always @(posedge clk) pc <= pc + 1;

    // Model timeline per period: 0 idle, 1 contact (bounce/press), 2 gap
    int         phase_a [NP];
    bit         press_a [NP];
    logic [3:0] key_a   [NP];
    logic [3:0] row_a   [NP];
    bit         rst_a   [NP];
    int         done_q  [$];
    int         free_p;
    int         abort_at;
    int         tests = 0;
    int         fails = 0;
    int         rmode;
    logic [3:0] rfix;

    int kmap [4][4] = '{'{7, 4, 1, 0}, '{8, 5, 2, 10}, '{9, 6, 3, 11}, '{15, 14, 13, 12}};

    function automatic logic [3:0] exp_col_for(input logic [3:0] k, input logic [3:0] row);
        logic [3:0] res;
        res = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (kmap[r][c] == int'(k) && row == ~(4'b0001 << r))
                    res = ~(4'b0001 << c);
        return res;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s period=%0d got=%0h expected=%0h", nm, pc, act, exp);
        end
    endtask

    // Fill the timeline for a command accepted at edge a (it owns periods a onward).
    task automatic model_cmd(input int a, input logic [3:0] k, input int h_raw, input int off);
        int h, p, ab;
        bit stop;
        h    = (h_raw == 0) ? 1 : h_raw;
        p    = a;
        ab   = (off >= 0) ? a + off : -1;
        stop = 1'b0;
        for (int i = 0; i < B && !stop; i++) begin
            phase_a[p] = 1; press_a[p] = (i % 2 == 0); key_a[p] = k;
            if (p == ab) stop = 1'b1;
            p++;
        end
        for (int i = 0; i < h && !stop; i++) begin
            phase_a[p] = 1; press_a[p] = 1'b1; key_a[p] = k;
            if (p == ab) stop = 1'b1;
            p++;
        end
        for (int i = 0; i < G; i++) begin
            phase_a[p] = 2; press_a[p] = 1'b0;
            p++;
        end
        done_q.push_back(p - 1);
        free_p   = p;
        abort_at = ab;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (rmode)
            0:       kp_row = ~(4'b0001 << $urandom_range(0, 3));
            1:       kp_row = 4'($urandom);
            2:       kp_row = rfix;
            default: kp_row = pc[0] ? 4'b1101 : 4'b1110;
        endcase
        // Aborts outside a contact phase must be ignored, so sprinkle some there
        cmd_if.cmd_abort = (pc == abort_at) || (phase_a[pc] != 1 && $urandom_range(0, 5) == 0);
    endtask

    task automatic issue(input logic [3:0] k, input int h, input int off);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_key   = k;
        cmd_if.cmd_hold  = 8'(h);
        while (pc < free_p) tick();
        model_cmd(pc + 1, k, h, off);
        tick();
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_key   = 4'($urandom);
        cmd_if.cmd_hold  = 8'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int p = pc + 1; p < NP; p++) begin
            phase_a[p] = 0;
            press_a[p] = 1'b0;
        end
        while (done_q.size() > 0 && done_q[$] > pc) void'(done_q.pop_back());
        free_p   = pc + 1;
        abort_at = -1;
        tick();
        rst = 1'b0;
    endtask

    // Monitor: per-period output checks and done-event scoreboard
    initial begin
        int         e;
        logic [3:0] ec;
        forever begin
            @(negedge clk);
            if (pc >= 1 && pc < NP) begin
                row_a[pc] = kp_row;
                rst_a[pc] = rst;
                ec = (rst_a[pc-1] || !press_a[pc-1]) ? 4'hF
                                                     : exp_col_for(key_a[pc-1], row_a[pc-1]);
                chk("kp_col", 32'(kp_col), 32'(ec));
                chk("cmd_ready", 32'(cmd_if.cmd_ready), 32'(phase_a[pc] == 0));
                chk("busy", 32'(busy), 32'(phase_a[pc] != 0));
                if (done) begin
                    if (done_q.size() == 0) begin
                        chk("done_unexpected", 32'(done), 32'(0));
                    end else begin
                        e = done_q.pop_front();
                        chk("done_period", 32'(pc), 32'(e));
                    end
                end else if (done_q.size() > 0 && done_q[0] <= pc) begin
                    void'(done_q.pop_front());
                    chk("done_missed", 32'(done), 32'(1));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog period=%0d got=timeout expected=finish", pc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, h, off;
        rst              = 1'b1;
        kp_row           = 4'hF;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_key   = '0;
        cmd_if.cmd_hold  = '0;
        cmd_if.cmd_abort = 1'b0;
        rmode            = 0;
        rfix             = 4'hF;
        free_p           = 0;
        abort_at         = -1;
        rst_a[0]         = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        rmode = 3;                 issue(4'hA, 5, -1);
        rmode = 2; rfix = 4'b1110; issue(4'h0, 0, -1);
        rmode = 0;                 issue(4'h8, 20, B + 2);
        issue(4'h7, 6, -1);
        issue(4'h5, 4, -1);
        issue(4'h3, 10, -1);
        repeat (4) tick();
        do_reset();
`ifdef KP_EMU_BOUNCE_EN
        rmode = 2; rfix = 4'b1101; issue(4'h2, 3, -1);
`endif
        rmode = 1; issue(4'hC, 255, -1);

        for (int n = 0; n < 40; n++) begin
            rmode = $urandom_range(0, 3);
            rfix  = ~(4'b0001 << $urandom_range(0, 3));
            k     = $urandom_range(0, 15);
            h     = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            off   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, B + h + 2) : -1;
            repeat ($urandom_range(0, 2)) tick();
            issue(4'(k), h, off);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 6)) tick();
                do_reset();
            end
        end

        while (pc < free_p + 3) tick();
        chk("done_pending", 32'(done_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
